fwd_sel_ctrl: RTL
=================

// Module: fwd_sel_ctrl
// PURPOSE
//  Forwarding/hazard controller for the EX stage. Generates the registered 2-bit selects for the two
//  32-bit 4:1 ALU-operand muxes: RF value / EX-MEM result / MEM-WB result / immediate.
//  Tracks destination registers of in-flight instructions in its own EX/MEM/WB shadow pipeline.
//  Raises a one-cycle load-use stall.
// PARAMETERS
//  REG_W  5  register-specifier width (32 GPRs; register 0 is hard-wired zero)
// PORTS
//  clk           in   1      rising-edge clock
//  reset         in   1      synchronous, active-high reset
//  dec_valid     in   1      instruction in ID is valid
//  dec_rs        in   REG_W  ID source register A
//  dec_rt        in   REG_W  ID source register B
//  dec_uses_rt   in   1      ID instruction reads rt as an operand
//  dec_dst       in   REG_W  ID destination register
//  dec_regwrite  in   1      ID instruction writes dec_dst
//  dec_memread   in   1      ID instruction is a load
//  dec_alusrc    in   1      operand B is the immediate
//  flush         in   1      kill the instruction in ID (taken branch/jump)
//  sel_a         out  2      operand-A mux select for the instruction now in EX
//  sel_b         out  2      operand-B mux select for the instruction now in EX
//  ex_valid      out  1      EX stage holds a real (non-bubble) instruction
//  stall         out  1      hold PC and IF/ID this cycle (combinational)
// BEHAVIOUR
//  Select encoding: 00 = RF read data, 01 = EX/MEM ALU result, 10 = MEM/WB writeback data,
//  11 = sign-extended immediate.
//  - sel_a never takes the value 11.
//  Shadow pipeline:
//  - Three registered stages EX, MEM, WB; each holds {valid, dst, regwrite, memread}.
//  - Each stage advances every cycle.
//  - MEM <= EX; WB <= MEM; the old WB entry retires.
//  stall = dec_valid & ex.valid & ex.memread & ex.regwrite & (ex.dst != 0) &
//          ((dec_rs == ex.dst) | (dec_uses_rt & dec_rt == ex.dst)).
//  EX load on the next clock edge:
//  - If stall or flush, EX loads a bubble: all fields 0, ex_valid = 0, sel_a = sel_b = 00.
//  - Otherwise EX loads the dec_* fields and the computed selects.
//  Operand-A select for the incoming instruction (computed in ID, registered into EX):
//  - 01 if ex.valid & ex.regwrite & ex.dst != 0 & ex.dst == dec_rs;
//  - else 10 if the same match holds against the MEM entry;
//  - else 00.
//  - EX match has priority over MEM match (youngest producer wins).
//  Operand-B select:
//  - 11 if dec_alusrc, regardless of any hazard;
//  - otherwise the same rule as operand A, applied to dec_rt.
//  Other rules:
//  - A producer currently in WB is never forwarded: the register file writes first half-cycle
//    and reads second, so sel = 00.
//  - Register 0 never matches, so its sel is 00.
//  - Latency: selects appear exactly 1 cycle after the instruction is presented in ID, aligned
//    with ex_valid.
//  - After a load-use stall, the load is in MEM on the next cycle, so the held instruction
//    receives sel 10.
//  - Stall is never asserted on two consecutive cycles for the same instruction.
//  - flush and stall in the same cycle: a bubble is inserted, and stall still reports 1.
//    The fetch unit gives flush priority.
//  - When dec_valid = 0, a bubble is loaded (same as the stall case).
//  Reset (synchronous):
//  - All shadow stages are cleared; sel_a = sel_b = 00; ex_valid = 0; stall = 0 (all stages
//    are invalid).
//  - Reset asserted mid-stream discards every in-flight entry.
//  - The first instruction after reset sees no hazards.
// TESTING
//  1. add $3,$1,$2 then sub $4,$3,$5 back-to-back -> sub in EX: sel_a=01, sel_b=00, stall never 1.
//  2. add $3,.. ; nop ; or $6,$5,$3 -> or in EX: sel_a=00, sel_b=10.
//  3. lw $7,0($1) ; add $8,$7,$7 -> stall=1 for exactly 1 cycle, bubble (ex_valid=0), then add in EX
//     with sel_a=sel_b=10.
//  4. add $3,.. ; add $3,.. ; and $9,$3,$3 -> sel_a=sel_b=01 (newest producer wins).
//     addi $0,.. ; add $2,$0,$0 -> sel_a=sel_b=00.
//  5. addi $5,$1,4 after a producer of $5 into rt -> sel_b=11.
//     A flush cycle -> next ex_valid=0, sel 00.
//  6. reset high for 1 cycle while a lw-dependent pair is in flight -> next cycle all outputs 0.
//     Following dependent add: sel 00, no stall.

Source files
------------

// File: rtl/fwd_sel_ctrl.sv
// EX-stage forwarding/hazard controller: registered ALU-operand mux selects,
// a shadow EX/MEM pipeline of destination tags, and a one-cycle load-use stall.
module fwd_sel_ctrl #(
  parameter int REG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             dec_valid,
  input  logic [REG_W-1:0] dec_rs,
  input  logic [REG_W-1:0] dec_rt,
  input  logic             dec_uses_rt,
  input  logic [REG_W-1:0] dec_dst,
  input  logic             dec_regwrite,
  input  logic             dec_memread,
  input  logic             dec_alusrc,
  input  logic             flush,
  output logic [1:0]       sel_a,
  output logic [1:0]       sel_b,
  output logic             ex_valid,
  output logic             stall
);

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_EXM = 2'b01;
  localparam logic [1:0] SEL_MWB = 2'b10;
  localparam logic [1:0] SEL_IMM = 2'b11;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] dst;
    logic             regwrite;
    logic             memread;
  } ex_ent_t;

  // The MEM entry never needs memread (loads only stall from EX). The WB entry
  // is not kept at all: the RF writes before it reads, so a WB producer always
  // resolves to SEL_RF and its tag never influences any output.
  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] dst;
    logic             regwrite;
  } mem_ent_t;

  ex_ent_t  ex;
  mem_ent_t mem;
  logic [1:0] nxt_sel_a, nxt_sel_b;
  logic       load;

  function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] src,
                                         input ex_ent_t e, input mem_ent_t m);
    if (e.valid && e.regwrite && e.dst != '0 && e.dst == src)      return SEL_EXM;
    else if (m.valid && m.regwrite && m.dst != '0 && m.dst == src) return SEL_MWB;
    else                                                           return SEL_RF;
  endfunction

  always_comb begin
    stall = dec_valid & ex.valid & ex.memread & ex.regwrite & (ex.dst != '0) &
            ((dec_rs == ex.dst) | (dec_uses_rt & (dec_rt == ex.dst)));
    load      = dec_valid & ~stall & ~flush;
    nxt_sel_a = fwd_sel(dec_rs, ex, mem);
    nxt_sel_b = dec_alusrc ? SEL_IMM : fwd_sel(dec_rt, ex, mem);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex    <= '0;
      mem   <= '0;
      sel_a <= SEL_RF;
      sel_b <= SEL_RF;
    end else begin
      mem <= '{valid: ex.valid, dst: ex.dst, regwrite: ex.regwrite};
      if (load) begin
        ex    <= '{valid: 1'b1, dst: dec_dst, regwrite: dec_regwrite, memread: dec_memread};
        sel_a <= nxt_sel_a;
        sel_b <= nxt_sel_b;
      end else begin
        ex    <= '0;
        sel_a <= SEL_RF;
        sel_b <= SEL_RF;
      end
    end
  end

  assign ex_valid = ex.valid;

endmodule
